// File: rtl/sc_game_pkg.sv
// Shared game-control definitions: FSM state encoding and default game constants,
// also used by the obstacle generator.
package sc_game_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StPlay = 2'b01,
    StHit  = 2'b10,
    StOver = 2'b11
  } gameState_e;

  localparam int unsigned LivesInitDef    = 3;
  localparam int unsigned HitHoldTicksDef = 4;

endpackage

// File: rtl/sc_collision_game_ctrl_if.sv
// Bundles the comparator-side inputs and the game-status outputs of the collision controller.
interface sc_collision_game_ctrl_if #(
  parameter int unsigned LIVES_WIDTH = 2,
  parameter int unsigned SCORE_WIDTH = 8
);

  logic                   SC_COLLISIONCTRL_start_InLow;
  logic                   SC_COLLISIONCTRL_rowtick_In;
  logic                   SC_COLLISIONCTRL_noCollide_In;
  logic [1:0]             SC_COLLISIONCTRL_state_Out;
  logic [LIVES_WIDTH-1:0] SC_COLLISIONCTRL_lives_Out;
  logic [SCORE_WIDTH-1:0] SC_COLLISIONCTRL_score_Out;
  logic                   SC_COLLISIONCTRL_playEn_Out;
  logic                   SC_COLLISIONCTRL_hit_Out;
  logic                   SC_COLLISIONCTRL_gameOver_Out;

  modport master (
    output SC_COLLISIONCTRL_start_InLow,
    output SC_COLLISIONCTRL_rowtick_In,
    output SC_COLLISIONCTRL_noCollide_In,
    input  SC_COLLISIONCTRL_state_Out,
    input  SC_COLLISIONCTRL_lives_Out,
    input  SC_COLLISIONCTRL_score_Out,
    input  SC_COLLISIONCTRL_playEn_Out,
    input  SC_COLLISIONCTRL_hit_Out,
    input  SC_COLLISIONCTRL_gameOver_Out
  );

  modport slave (
    input  SC_COLLISIONCTRL_start_InLow,
    input  SC_COLLISIONCTRL_rowtick_In,
    input  SC_COLLISIONCTRL_noCollide_In,
    output SC_COLLISIONCTRL_state_Out,
    output SC_COLLISIONCTRL_lives_Out,
    output SC_COLLISIONCTRL_score_Out,
    output SC_COLLISIONCTRL_playEn_Out,
    output SC_COLLISIONCTRL_hit_Out,
    output SC_COLLISIONCTRL_gameOver_Out
  );

endinterface

// File: rtl/sc_fall_edge_detect.sv
// Registered high->low edge detector; the pulse comes from registers only, one cycle after
// the sampled level changes.
module sc_fall_edge_detect #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rstN,
  input  logic sigIn,
  output logic fallEdge
);

  logic sampleQ;
  logic armedQ;
  logic edgeQ;

  // armedQ suppresses the first post-reset sample, so a level already low at reset
  // release is not mistaken for a fresh press.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      sampleQ <= RESET_VAL;
      armedQ  <= 1'b0;
      edgeQ   <= 1'b0;
    end else begin
      sampleQ <= sigIn;
      armedQ  <= 1'b1;
      edgeQ   <= armedQ & sampleQ & ~sigIn;
    end
  end

  assign fallEdge = edgeQ;

endmodule

// File: rtl/sc_collision_game_ctrl.sv
// Game-control stage after the player position comparator: lives, score, hit hold-off and
// the IDLE/PLAY/HIT/OVER FSM that gates the obstacle shifter.
module sc_collision_game_ctrl
  import sc_game_pkg::*;
#(
  parameter int unsigned LIVES_INIT     = LivesInitDef,
  parameter int unsigned LIVES_WIDTH    = 2,
  parameter int unsigned SCORE_WIDTH    = 8,
  parameter int unsigned HIT_HOLD_TICKS = HitHoldTicksDef,
  parameter int unsigned HOLD_WIDTH     = 3
) (
  input logic                     SC_COLLISIONCTRL_CLOCK_50,
  input logic                     SC_COLLISIONCTRL_RESET_InLow,
  sc_collision_game_ctrl_if.slave bus
);

  localparam logic [LIVES_WIDTH-1:0] LivesInitVal = LIVES_INIT[LIVES_WIDTH-1:0];
  localparam logic [HOLD_WIDTH-1:0]  HoldInitVal  = HIT_HOLD_TICKS[HOLD_WIDTH-1:0];
  localparam logic [SCORE_WIDTH-1:0] ScoreMax     = {SCORE_WIDTH{1'b1}};

  logic clk;
  logic rstN;
  logic startEdge;
  logic rowtick;
  logic noCollide;

  gameState_e             stateQ, stateD;
  logic [LIVES_WIDTH-1:0] livesQ, livesD;
  logic [SCORE_WIDTH-1:0] scoreQ, scoreD;
  logic [HOLD_WIDTH-1:0]  holdQ, holdD;
  logic                   playEnQ, hitQ, gameOverQ;

  assign clk       = SC_COLLISIONCTRL_CLOCK_50;
  assign rstN      = SC_COLLISIONCTRL_RESET_InLow;
  assign rowtick   = bus.SC_COLLISIONCTRL_rowtick_In;
  assign noCollide = bus.SC_COLLISIONCTRL_noCollide_In;

  sc_fall_edge_detect #(
    .RESET_VAL(1'b1)
  ) u_startEdge (
    .clk     (clk),
    .rstN    (rstN),
    .sigIn   (bus.SC_COLLISIONCTRL_start_InLow),
    .fallEdge(startEdge)
  );

  always_comb begin
    stateD = stateQ;
    livesD = livesQ;
    scoreD = scoreQ;
    holdD  = holdQ;
    unique case (stateQ)
      // A start edge takes priority over any coincident rowtick.
      StIdle, StOver: begin
        if (startEdge) begin
          stateD = StPlay;
          livesD = LivesInitVal;
          scoreD = '0;
        end
      end
      StPlay: begin
        if (rowtick) begin
          if (noCollide) begin
            if (scoreQ != ScoreMax) begin
              scoreD = scoreQ + SCORE_WIDTH'(1);
            end
          end else if (livesQ > LIVES_WIDTH'(1)) begin
            livesD = livesQ - LIVES_WIDTH'(1);
            holdD  = HoldInitVal;
            stateD = StHit;
          end else begin
            livesD = '0;
            stateD = StOver;
          end
        end
      end
      StHit: begin
        if (rowtick) begin
          if (holdQ != '0) begin
            holdD = holdQ - HOLD_WIDTH'(1);
          end
          if (holdQ <= HOLD_WIDTH'(1)) begin
            stateD = StPlay;
          end
        end
      end
      default: stateD = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      stateQ    <= StIdle;
      livesQ    <= LivesInitVal;
      scoreQ    <= '0;
      holdQ     <= '0;
      playEnQ   <= 1'b0;
      hitQ      <= 1'b0;
      gameOverQ <= 1'b0;
    end else begin
      stateQ    <= stateD;
      livesQ    <= livesD;
      scoreQ    <= scoreD;
      holdQ     <= holdD;
      // Flags decoded from the next state so they line up with the state register.
      playEnQ   <= (stateD == StPlay);
      hitQ      <= (stateD == StHit);
      gameOverQ <= (stateD == StOver);
    end
  end

  assign bus.SC_COLLISIONCTRL_state_Out    = stateQ;
  assign bus.SC_COLLISIONCTRL_lives_Out    = livesQ;
  assign bus.SC_COLLISIONCTRL_score_Out    = scoreQ;
  assign bus.SC_COLLISIONCTRL_playEn_Out   = playEnQ;
  assign bus.SC_COLLISIONCTRL_hit_Out      = hitQ;
  assign bus.SC_COLLISIONCTRL_gameOver_Out = gameOverQ;

endmodule
